slave_write_ctrl: RTL and testbench

SLAVE_WRITE_CTRL -- requirements
Module: slave_write_ctrl

---
 rtl/slave_write_ctrl.sv | 102 ++++++++++
 tb/tb_slave_write_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/slave_write_ctrl.sv
// slave_write_ctrl: single-burst AXI write slave that turns W beats into memory write strobes
//   AW channel : AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID in, AWREADY out
//   W channel  : WDATA/WSTRB/WLAST/WVALID in, WREADY out
//   B channel  : BID/BRESP/BVALID out, BREADY in
//   memory     : mem_we/mem_addr/mem_wdata/mem_wstrb out (mem_we is combinational)
module slave_write_ctrl #(
  parameter int          IDS_BITS = 8,
  parameter logic [31:0] ADDR_LO  = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI  = 32'h0000_FFFF
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [IDS_BITS-1:0] AWID,
  input  logic [31:0]         AWADDR,
  input  logic [3:0]          AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         WDATA,
  input  logic [3:0]          WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [IDS_BITS-1:0] BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb
);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t              state;
  logic [IDS_BITS-1:0] id_q;
  logic [31:0]         addr_q;
  logic [3:0]          len_q;
  logic [3:0]          cnt;
  logic                incr_q;
  logic                dec_err;
  logic                slv_err;
  logic                bad_burst;
  logic                aw_hs;
  logic                w_hs;
  logic                out_of_range;
  logic [32:0]         lo_diff;
  logic [32:0]         hi_diff;
  logic                unused;
  assign unused = ^AWSIZE;
  // range decode by borrow of 33-bit subtraction: a borrow means the address lies outside
  assign lo_diff      = {1'b0, AWADDR} - {1'b0, ADDR_LO};
  assign hi_diff      = {1'b0, ADDR_HI} - {1'b0, AWADDR};
  assign out_of_range = lo_diff[32] | hi_diff[32];
  assign AWREADY   = state == IDLE;
  assign WREADY    = state == DATA;
  assign BVALID    = state == RESP;
  assign aw_hs     = AWVALID & AWREADY;
  assign w_hs      = WVALID & WREADY;
  assign BID       = id_q;
  assign BRESP     = dec_err ? 2'b11 : slv_err ? 2'b10 : 2'b00;
  assign mem_we    = w_hs & ~dec_err & ~bad_burst;
  assign mem_addr  = addr_q;
  assign mem_wdata = WDATA;
  assign mem_wstrb = WSTRB;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      incr_q    <= 1'b0;
      dec_err   <= 1'b0;
      slv_err   <= 1'b0;
      bad_burst <= 1'b0;
    end else begin
      case (state)
        IDLE: if (aw_hs) begin
          state     <= DATA;
          id_q      <= AWID;
          addr_q    <= AWADDR;
          len_q     <= AWLEN;
          cnt       <= '0;
          incr_q    <= AWBURST == 2'b01;
          dec_err   <= out_of_range;
          slv_err   <= AWBURST[1];
          bad_burst <= AWBURST[1];
        end
        DATA: if (w_hs) begin
          cnt    <= cnt + 4'd1;
          addr_q <= incr_q ? addr_q + 32'd4 : addr_q;
          // WLAST must appear on the final beat and nowhere else
          if ((cnt == len_q) != WLAST) slv_err <= 1'b1;
          if (cnt == len_q) state <= RESP;
        end
        RESP: if (BREADY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_slave_write_ctrl.sv
// tb_slave_write_ctrl: table-driven burst checks plus hand sequences for reset and backpressure
module tb_slave_write_ctrl;
  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [3:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = 3'd2;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        BREADY = 1'b0;
  logic        sel = 1'b0;
  logic        awready_a, wready_a, bvalid_a, we_a;
  logic        awready_b, wready_b, bvalid_b, we_b;
  logic [7:0]  bid_a, bid_b;
  logic [1:0]  bresp_a, bresp_b;
  logic [31:0] addr_a, addr_b, wdata_a, wdata_b;
  logic [3:0]  wstrb_a, wstrb_b;
  logic        awready, wready, bvalid, mem_we;
  logic [7:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  int          checks = 0;
  int          errors = 0;

  always #5 ACLK = ~ACLK;

  slave_write_ctrl dut_a (
    .ACLK(ACLK), .ARESETn(ARESETn), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(awready_a),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(wready_a),
    .BID(bid_a), .BRESP(bresp_a), .BVALID(bvalid_a), .BREADY(BREADY),
    .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wstrb(wstrb_a));

  slave_write_ctrl #(.ADDR_HI(32'hFFFF_FFFF)) dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
    .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(awready_b),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(wready_b),
    .BID(bid_b), .BRESP(bresp_b), .BVALID(bvalid_b), .BREADY(BREADY),
    .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wstrb(wstrb_b));

  assign awready   = sel ? awready_b : awready_a;
  assign wready    = sel ? wready_b  : wready_a;
  assign bvalid    = sel ? bvalid_b  : bvalid_a;
  assign mem_we    = sel ? we_b      : we_a;
  assign bid       = sel ? bid_b     : bid_a;
  assign bresp     = sel ? bresp_b   : bresp_a;
  assign mem_addr  = sel ? addr_b    : addr_a;
  assign mem_wdata = sel ? wdata_b   : wdata_a;
  assign mem_wstrb = sel ? wstrb_b   : wstrb_a;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [7:0]  id;
    logic [15:0] last_mask;
    logic [3:0]  strb;
    logic [31:0] step;
    logic        exp_we;
    logic [1:0]  exp_resp;
    int          bp;
    logic        use_b;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic run_burst(input vec_t v);
    logic [31:0] exp_addr;
    sel     = v.use_b;
    AWID    = v.id;
    AWADDR  = v.addr;
    AWLEN   = v.len;
    AWBURST = v.burst;
    AWVALID = 1'b1;
    #1;
    chk("aw_ready_idle", {31'b0, awready}, 1);
    chk("w_ready_idle", {31'b0, wready}, 0);
    cyc();
    AWVALID = 1'b0;
    #1;
    chk("w_ready_data", {31'b0, wready}, 1);
    chk("aw_ready_data", {31'b0, awready}, 0);
    exp_addr = v.addr;
    for (int i = 0; i <= int'(v.len); i++) begin
      WVALID = 1'b1;
      WDATA  = 32'hA500_0000 + i;
      WSTRB  = v.strb;
      WLAST  = v.last_mask[i];
      #1;
      chk("mem_we", {31'b0, mem_we}, {31'b0, v.exp_we});
      if (v.exp_we) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, 32'hA500_0000 + i);
        chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, v.strb});
      end
      exp_addr = exp_addr + v.step;
      cyc();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    #1;
    chk("b_valid", {31'b0, bvalid}, 1);
    chk("b_id", {24'b0, bid}, {24'b0, v.id});
    chk("b_resp", {30'b0, bresp}, {30'b0, v.exp_resp});
    for (int k = 0; k < v.bp; k++) begin
      AWVALID = 1'b1;
      AWID    = 8'hEE;
      WVALID  = 1'b1;
      #1;
      chk("bp_aw_ready", {31'b0, awready}, 0);
      chk("bp_mem_we", {31'b0, mem_we}, 0);
      cyc();
      chk("bp_b_valid", {31'b0, bvalid}, 1);
      chk("bp_b_id", {24'b0, bid}, {24'b0, v.id});
      chk("bp_b_resp", {30'b0, bresp}, {30'b0, v.exp_resp});
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    BREADY  = 1'b1;
    cyc();
    BREADY = 1'b0;
    #1;
    chk("idle_aw_ready", {31'b0, awready}, 1);
    chk("idle_b_valid", {31'b0, bvalid}, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 4'd3, 2'b01, 8'h15, 16'h0008, 4'hF, 32'd4, 1'b1, 2'b00, 0, 1'b0};
    vecs[1] = '{32'h0001_0000, 4'd1, 2'b01, 8'h02, 16'h0002, 4'hF, 32'd4, 1'b0, 2'b11, 0, 1'b0};
    vecs[2] = '{32'h0000_0200, 4'd2, 2'b01, 8'h03, 16'h0002, 4'h3, 32'd4, 1'b1, 2'b10, 0, 1'b0};
    vecs[3] = '{32'h0000_0300, 4'd2, 2'b01, 8'h04, 16'h0000, 4'hC, 32'd4, 1'b1, 2'b10, 0, 1'b0};
    vecs[4] = '{32'h0000_FFFC, 4'd2, 2'b00, 8'h05, 16'h0004, 4'hF, 32'd0, 1'b1, 2'b00, 0, 1'b0};
    vecs[5] = '{32'h0000_0400, 4'd1, 2'b10, 8'h06, 16'h0002, 4'hF, 32'd4, 1'b0, 2'b10, 0, 1'b0};
    vecs[6] = '{32'h0000_0500, 4'd0, 2'b01, 8'h07, 16'h0001, 4'h1, 32'd4, 1'b1, 2'b00, 5, 1'b0};
    vecs[7] = '{32'h0000_0600, 4'd0, 2'b01, 8'h08, 16'h0001, 4'h0, 32'd4, 1'b1, 2'b00, 0, 1'b0};
    vecs[8] = '{32'hFFFF_FFFC, 4'd1, 2'b01, 8'h09, 16'h0002, 4'hF, 32'd4, 1'b1, 2'b00, 0, 1'b1};
    cyc();
    cyc();
    chk("rst_aw_ready", {31'b0, awready}, 1);
    chk("rst_w_ready", {31'b0, wready}, 0);
    chk("rst_b_valid", {31'b0, bvalid}, 0);
    chk("rst_b_resp", {30'b0, bresp}, 0);
    ARESETn = 1'b1;
    cyc();
    for (int n = 0; n < 9; n++) run_burst(vecs[n]);
    sel     = 1'b0;
    AWID    = 8'h3C;
    AWADDR  = 32'h0000_0700;
    AWLEN   = 4'd3;
    AWBURST = 2'b01;
    AWVALID = 1'b1;
    cyc();
    AWVALID = 1'b0;
    WVALID  = 1'b1;
    WDATA   = 32'h1234_5678;
    WSTRB   = 4'hF;
    #1;
    chk("pre_rst_mem_we", {31'b0, mem_we}, 1);
    cyc();
    #2;
    ARESETn = 1'b0;
    #1;
    chk("async_aw_ready", {31'b0, awready}, 1);
    chk("async_w_ready", {31'b0, wready}, 0);
    chk("async_b_valid", {31'b0, bvalid}, 0);
    chk("async_b_id", {24'b0, bid}, 0);
    chk("async_b_resp", {30'b0, bresp}, 0);
    chk("async_mem_we", {31'b0, mem_we}, 0);
    cyc();
    chk("held_rst_mem_we", {31'b0, mem_we}, 0);
    WVALID  = 1'b0;
    ARESETn = 1'b1;
    cyc();
    chk("post_rst_b_valid", {31'b0, bvalid}, 0);
    run_burst('{32'h0000_0800, 4'd0, 2'b01, 8'h2A, 16'h0001, 4'hF, 32'd4, 1'b1, 2'b00, 0, 1'b0});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
